// File: rtl/ps2_keyboard_state.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_state
// Brief    : PS/2 scan code set 2 byte-stream decoder. Strips E0/F0/E1
//            prefixes, tracks held modifiers and caps lock, and emits one
//            ready pulse per non-modifier key press (typematic included).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_state #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_code_ready,
  input  logic [7:0] scan_code,
  output logic       keyboard_state_ready,
  output logic [7:0] scan_code_out,
  output logic       scan_code_extended,
  output logic       keyboard_shift,
  output logic       keyboard_ctrl,
  output logic       keyboard_alt,
  output logic       keyboard_altgr,
  output logic       keyboard_meta,
  output logic       keyboard_capslock
);

  localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT_E0   = 3'd1,
    ST_GOT_F0   = 3'd2,
    ST_GOT_E0F0 = 3'd3,
    ST_SKIP_E1  = 3'd4
  } state_t;

  state_t          state_q,     state_d;
  logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
  logic [2:0]      skip_q,      skip_d;
  logic            lshift_q,    lshift_d;
  logic            rshift_q,    rshift_d;
  logic            lctrl_q,     lctrl_d;
  logic            rctrl_q,     rctrl_d;
  logic            lalt_q,      lalt_d;
  logic            ralt_q,      ralt_d;
  logic            lgui_q,      lgui_d;
  logic            rgui_q,      rgui_d;
  logic            caps_held_q, caps_held_d;
  logic            capslock_q,  capslock_d;
  logic            ready_q,     ready_d;
  logic [7:0]      code_q,      code_d;
  logic            ext_q,       ext_d;

  // Per-byte classification produced by the prefix parser
  logic            key_make;
  logic            key_break;
  logic            key_ext;
  logic            bat_ok;
  logic            pause_evt;
  logic            emit;

  // Prefix parser, held-key tracking and event generation
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    skip_d      = skip_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    lgui_d      = lgui_q;
    rgui_d      = rgui_q;
    caps_held_d = caps_held_q;
    capslock_d  = capslock_q;
    ready_d     = 1'b0;
    code_d      = code_q;
    ext_d       = ext_q;
    key_make    = 1'b0;
    key_break   = 1'b0;
    key_ext     = 1'b0;
    bat_ok      = 1'b0;
    pause_evt   = 1'b0;
    emit        = 1'b0;

    if (scan_code_ready) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (scan_code)
            8'hE0: state_d = ST_GOT_E0;
            8'hF0: state_d = ST_GOT_F0;
            8'hE1: begin
              state_d = ST_SKIP_E1;
              skip_d  = 3'd7;
            end
            8'hAA: bat_ok = 1'b1;
            8'h00, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin end
            default: key_make = 1'b1;
          endcase
        end
        ST_GOT_E0: begin
          state_d = ST_IDLE;
          case (scan_code)
            8'hF0: state_d = ST_GOT_E0F0;
            8'hE0: state_d = ST_GOT_E0;
            // Fake shifts wrapped around print screen and friends
            8'h12, 8'h59: begin end
            default: begin
              key_make = 1'b1;
              key_ext  = 1'b1;
            end
          endcase
        end
        ST_GOT_F0: begin
          state_d   = ST_IDLE;
          key_break = 1'b1;
        end
        ST_GOT_E0F0: begin
          state_d = ST_IDLE;
          if (scan_code != 8'h12 && scan_code != 8'h59) begin
            key_break = 1'b1;
            key_ext   = 1'b1;
          end
        end
        ST_SKIP_E1: begin
          // Pause sends E1 plus seven opaque bytes; only the count matters
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            pause_evt = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is dropped so a lost byte cannot wedge the decoder
      if (to_cnt_q == TO_LAST) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    if (bat_ok) begin
      lshift_d    = 1'b0;
      rshift_d    = 1'b0;
      lctrl_d     = 1'b0;
      rctrl_d     = 1'b0;
      lalt_d      = 1'b0;
      ralt_d      = 1'b0;
      lgui_d      = 1'b0;
      rgui_d      = 1'b0;
      caps_held_d = 1'b0;
      capslock_d  = 1'b0;
    end

    if (key_make) begin
      if (!key_ext) begin
        case (scan_code)
          8'h12: lshift_d = 1'b1;
          8'h59: rshift_d = 1'b1;
          8'h14: lctrl_d  = 1'b1;
          8'h11: lalt_d   = 1'b1;
          8'h58: begin
            // Typematic repeats of caps lock must not keep toggling it
            if (!caps_held_q) capslock_d = ~capslock_q;
            caps_held_d = 1'b1;
          end
          default: emit = 1'b1;
        endcase
      end else begin
        case (scan_code)
          8'h14: rctrl_d = 1'b1;
          8'h11: ralt_d  = 1'b1;
          8'h1F: lgui_d  = 1'b1;
          8'h27: rgui_d  = 1'b1;
          default: emit = 1'b1;
        endcase
      end
    end

    if (key_break) begin
      if (!key_ext) begin
        case (scan_code)
          8'h12: lshift_d    = 1'b0;
          8'h59: rshift_d    = 1'b0;
          8'h14: lctrl_d     = 1'b0;
          8'h11: lalt_d      = 1'b0;
          8'h58: caps_held_d = 1'b0;
          default: begin end
        endcase
      end else begin
        case (scan_code)
          8'h14: rctrl_d = 1'b0;
          8'h11: ralt_d  = 1'b0;
          8'h1F: lgui_d  = 1'b0;
          8'h27: rgui_d  = 1'b0;
          default: begin end
        endcase
      end
    end

    if (emit) begin
      ready_d = 1'b1;
      code_d  = scan_code;
      ext_d   = key_ext;
    end

    if (pause_evt) begin
      ready_d = 1'b1;
      code_d  = 8'h77;
      ext_d   = 1'b1;
    end
  end

  // State, flag and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      skip_q      <= 3'd0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      lgui_q      <= 1'b0;
      rgui_q      <= 1'b0;
      caps_held_q <= 1'b0;
      capslock_q  <= 1'b0;
      ready_q     <= 1'b0;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      skip_q      <= skip_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      lgui_q      <= lgui_d;
      rgui_q      <= rgui_d;
      caps_held_q <= caps_held_d;
      capslock_q  <= capslock_d;
      ready_q     <= ready_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
    end
  end

  assign keyboard_state_ready = ready_q;
  assign scan_code_out        = code_q;
  assign scan_code_extended   = ext_q;
  assign keyboard_shift       = lshift_q | rshift_q;
  assign keyboard_ctrl        = lctrl_q | rctrl_q;
  assign keyboard_alt         = lalt_q;
  assign keyboard_altgr       = ralt_q;
  assign keyboard_meta        = lgui_q | rgui_q;
  assign keyboard_capslock    = capslock_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_state
// Brief    : Scoreboard bench for ps2_keyboard_state. A sequence-level model
//            of the byte stream predicts events and modifier state; a monitor
//            compares the DUT against it on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_state;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_code_ready = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       keyboard_state_ready;
  logic [7:0] scan_code_out;
  logic       scan_code_extended;
  logic       keyboard_shift, keyboard_ctrl, keyboard_alt;
  logic       keyboard_altgr, keyboard_meta, keyboard_capslock;

  ps2_keyboard_state #(.TIMEOUT_CYCLES(T)) dut (
    .clk                  (clk),
    .reset                (reset),
    .scan_code_ready      (scan_code_ready),
    .scan_code            (scan_code),
    .keyboard_state_ready (keyboard_state_ready),
    .scan_code_out        (scan_code_out),
    .scan_code_extended   (scan_code_extended),
    .keyboard_shift       (keyboard_shift),
    .keyboard_ctrl        (keyboard_ctrl),
    .keyboard_alt         (keyboard_alt),
    .keyboard_altgr       (keyboard_altgr),
    .keyboard_meta        (keyboard_meta),
    .keyboard_capslock    (keyboard_capslock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic [5:0] mods;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  bit         held[int];   // key id = ext*256 + code, present while key is down
  logic       caps = 1'b0;
  logic [7:0] seq[$];      // bytes of the message currently being assembled

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // {shift, ctrl, alt, altgr, meta, capslock} implied by the held-key set
  function automatic logic [5:0] mods();
    logic [5:0] m;
    m[5] = held.exists(12'h012) || held.exists(12'h059);
    m[4] = held.exists(12'h014) || held.exists(12'h114);
    m[3] = held.exists(12'h011);
    m[2] = held.exists(12'h111);
    m[1] = held.exists(12'h11F) || held.exists(12'h127);
    m[0] = caps;
    return m;
  endfunction

  function automatic logic [5:0] dut_mods();
    return {keyboard_shift, keyboard_ctrl, keyboard_alt,
            keyboard_altgr, keyboard_meta, keyboard_capslock};
  endfunction

  function automatic void emit(logic [7:0] code, logic ext);
    ev_t e;
    e.code = code;
    e.ext  = ext;
    e.mods = mods();
    e.cyc  = cyc;
    exp_q.push_back(e);
  endfunction

  function automatic void make(logic [7:0] code, logic ext);
    int key;
    key = (ext ? 256 : 0) + int'(code);
    if (key inside {12'h012, 12'h059, 12'h014, 12'h114, 12'h011, 12'h111, 12'h11F, 12'h127}) begin
      held[key] = 1'b1;
    end else if (key == 12'h058) begin
      if (!held.exists(key)) caps = ~caps;
      held[key] = 1'b1;
    end else begin
      emit(code, ext);
    end
  endfunction

  function automatic void brk(logic [7:0] code, logic ext);
    int key;
    key = (ext ? 256 : 0) + int'(code);
    if (held.exists(key)) held.delete(key);
  endfunction

  // Assemble bytes into whole messages and apply each completed one
  function automatic void model_byte(logic [7:0] b);
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin
        emit(8'h77, 1'b1);
        seq.delete();
      end
      return;
    end
    if (seq.size() == 1) begin
      if (b == 8'hE0 || b == 8'hF0) return;
      if (b == 8'hAA) begin
        held.delete();
        caps = 1'b0;
      end else if (!(b inside {8'h00, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
        make(b, 1'b0);
      end
      seq.delete();
      return;
    end
    if (seq[0] == 8'hF0) begin
      brk(b, 1'b0);
      seq.delete();
      return;
    end
    if (seq.size() == 2) begin
      if (b == 8'hE0) begin
        seq.delete();
        seq.push_back(8'hE0);
        return;
      end
      if (b == 8'hF0) return;
      if (!(b inside {8'h12, 8'h59})) make(b, 1'b1);
      seq.delete();
      return;
    end
    if (!(b inside {8'h12, 8'h59})) brk(b, 1'b1);
    seq.delete();
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 after gap idle cycles
  task automatic send(input logic [7:0] b, input int gap);
    scan_code       = b;
    scan_code_ready = 1'b1;
    @(posedge clk);
    #1;
    scan_code_ready = 1'b0;
    scan_code       = 8'($urandom);
    model_byte(b);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (gap >= T) seq.delete();
  endtask

  function automatic void chk_all_zero(string name);
    chk(name, {keyboard_state_ready, scan_code_out, scan_code_extended, dut_mods()}, 32'h0);
  endfunction

  task automatic do_reset();
    reset           = 1'b0;
    scan_code_ready = 1'b0;
    held.delete();
    caps = 1'b0;
    seq.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    reset = 1'b1;
  endtask

  // Scoreboard monitor: events and modifier state checked on falling edges
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        chk("modifiers", {26'h0, dut_mods()}, {26'h0, mods()});
        if (keyboard_state_ready !== 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {23'h0, keyboard_state_ready, scan_code_out}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("event", {17'h0, scan_code_extended, scan_code_out, dut_mods()},
                {17'h0, e.ext, e.code, e.mods});
            chk("event_cycle", cyc, e.cyc);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          chk("missing_event", {23'h0, keyboard_state_ready, scan_code_out}, {23'h1, e.code});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] pool [24] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1, 8'h12, 8'h59,
                            8'h14, 8'h11, 8'h1F, 8'h27, 8'h58, 8'h58, 8'h1C, 8'h1E,
                            8'h75, 8'h7C, 8'h77, 8'h2A, 8'hAA, 8'hFA, 8'h00, 8'h7C};

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Shifted key press, then breaks
    send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 0); send(8'h1C, 1);
    chk("t1_shift_held", keyboard_shift, 1);
    send(8'hF0, 0); send(8'h12, 2);
    chk("t1_shift_released", keyboard_shift, 0);

    // AltGr, extended key, single-cycle ready
    send(8'hE0, 0); send(8'h11, 1);
    chk("t2_altgr_set", keyboard_altgr, 1);
    send(8'h1E, 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h11, 1);
    chk("t2_altgr_clr", keyboard_altgr, 0);
    send(8'hE0, 0); send(8'h75, 3);
    chk("t2_held_out", {keyboard_state_ready, scan_code_extended, scan_code_out}, {2'b01, 8'h75});

    // Print screen with fake shifts
    send(8'hE0, 0); send(8'h12, 0); send(8'hE0, 0); send(8'h7C, 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h7C, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h12, 2);
    chk("t3_shift", keyboard_shift, 0);

    // Pause while left ctrl is down
    send(8'h14, 1);
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 2);
    chk("t4_ctrl_kept", keyboard_ctrl, 1);
    send(8'hF0, 0); send(8'h14, 1);

    // Caps lock with typematic repeats
    send(8'h58, 1); chk("t5_caps_1", keyboard_capslock, 1);
    send(8'h58, 0); send(8'h58, 1); chk("t5_caps_rep", keyboard_capslock, 1);
    send(8'hF0, 0); send(8'h58, 1); chk("t5_caps_brk", keyboard_capslock, 1);
    send(8'h58, 1); chk("t5_caps_0", keyboard_capslock, 0);

    // Prefix still pending shortly before the timeout, dropped after it
    send(8'hE0, T - 4); send(8'h1C, 1);
    chk("t6_pending_ext", scan_code_extended, 1);
    send(8'hE0, T + 2); send(8'h1C, 1);
    chk("t6_timeout_ext", scan_code_extended, 0);

    // BAT clears held keys and caps lock
    send(8'h12, 0); send(8'h58, 1); send(8'hAA, 1);
    chk("t6_bat", {keyboard_shift, keyboard_capslock}, 2'b00);

    // Asynchronous reset in the middle of a prefix
    send(8'h59, 0); send(8'h58, 0); send(8'h2A, 1); send(8'hE0, 0);
    #2;
    reset = 1'b0;
    held.delete();
    caps = 1'b0;
    seq.delete();
    exp_q.delete();
    #1;
    chk_all_zero("t6_reset_mid_prefix");
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'h1C, 1);
    chk("t6_after_reset", {scan_code_extended, scan_code_out}, {1'b0, 8'h1C});

    // Randomized byte stream
    do_reset();
    for (int i = 0; i < 800; i++) begin
      send(pool[$urandom_range(0, 23)], int'($urandom_range(0, 3)));
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pending_events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
